// File: rtl/sortvals_reader.sv
// sortvals_reader: captures a finished sort result and streams it out.
//
// The sorter presents a flat, ascending array and a level done flag.
// On the rising edge of that flag (seen while IDLE), the whole array is
// copied into a local buffer. The sorter is then free to be reset and
// reused while this block streams the buffered words. Words leave one at a
// time over a valid/ready handshake.
//
// All outputs are registered. The word that will be presented after a
// handshake is loaded straight from the buffer at the next pointer, so the
// outputs never depend combinationally on out_ready.

module sortvals_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 32,
    parameter bit ASCENDING  = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sort_done,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]  array_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [$clog2(NUM_WORDS)-1:0]     out_index,
    output logic                             out_last,
    output logic                             busy,
    output logic                             drained
);

    localparam int IDX_W = $clog2(NUM_WORDS);

    // First and final stream positions depend on the emit direction.
    localparam int FIRST_I = ASCENDING ? 0 : NUM_WORDS - 1;
    localparam int LAST_I  = ASCENDING ? NUM_WORDS - 1 : 0;
    localparam logic [IDX_W-1:0] FIRST_POS = IDX_W'(FIRST_I);
    localparam logic [IDX_W-1:0] LAST_POS  = IDX_W'(LAST_I);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STREAM  = 2'd1,
        S_DRAINED = 2'd2
    } state_t;

    state_t                state;
    logic                  done_q;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      next_ptr;
    logic                  rise;
    logic                  handshake;
    logic [DATA_WIDTH-1:0] data_buf [NUM_WORDS];

    // Capture needs a fresh rise of the level flag, not just a high level.
    assign rise      = sort_done & ~done_q;
    assign handshake = out_valid & out_ready;

    // Step one slot toward the final position. The state leaves STREAM on the
    // last handshake, so the pointer never actually wraps.
    assign next_ptr  = ASCENDING ? (ptr + 1'b1) : (ptr - 1'b1);

    assign out_index = ptr;

    // Main FSM: edge detect, capture, streaming, and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            done_q    <= 1'b0;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            drained   <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                data_buf[i] <= '0;
            end
        end else begin
            done_q <= sort_done;
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            data_buf[i] <= array_in[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        // Present the first word straight from the input, since
                        // the buffer is only being written at this same edge.
                        ptr       <= FIRST_POS;
                        out_data  <= array_in[FIRST_I*DATA_WIDTH +: DATA_WIDTH];
                        out_last  <= (FIRST_POS == LAST_POS);
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_STREAM;
                    end
                end

                S_STREAM: begin
                    if (handshake) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            drained   <= 1'b1;
                            state     <= S_DRAINED;
                        end else begin
                            ptr      <= next_ptr;
                            out_data <= data_buf[next_ptr];
                            out_last <= (next_ptr == LAST_POS);
                        end
                    end
                end

                S_DRAINED: begin
                    // Wait for the sorter to drop done, so that a level held
                    // high does not start a second stream.
                    if (!sort_done) begin
                        drained <= 1'b0;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                    drained   <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
